ysyx_22040127_lsu: RTL

Load/store unit sitting directly downstream of the execute stage. It consumes the execute stage's computed address/result together with the store data and memory-op fields. It drives a single-outstanding request/response data-memory bus with byte-lane masks, aligns and sign/zero-extends load data, and hands one result per instruction to writeback. Non-memory instructions pass through with one cycle of latency, so writeback sees a uniform valid/ready stream.

---
 rtl/ysyx_22040127_lsu_pkg.sv | 35 +++
 rtl/ysyx_22040127_lsu_align.sv | 49 ++++
 rtl/ysyx_22040127_lsu.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040127_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encodings, access-size codes,
// byte-lane mask lookup and the data-bus command layout.
package ysyx_22040127_lsu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int BUS_XLEN = 64;
  localparam int MASK_W   = 8;

  typedef struct packed {
    logic                we;
    logic [BUS_XLEN-1:0] addr;
    logic [BUS_XLEN-1:0] wdata;
    logic [MASK_W-1:0]   wmask;
  } bus_cmd_t;

  // Byte enables for an access of the given size starting at lane 0.
  function automatic logic [MASK_W-1:0] byte_mask(input logic [1:0] size);
    case (size)
      SZ_B:    byte_mask = 8'h01;
      SZ_H:    byte_mask = 8'h03;
      SZ_W:    byte_mask = 8'h0f;
      default: byte_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040127_lsu_align.sv
// Combinational lane alignment: store mask/data shifting, load extraction with
// sign/zero extension, and natural-alignment fault detection.
module ysyx_22040127_lsu_align
  import ysyx_22040127_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        addr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign
);

  logic [1:0]      size;
  logic            sext;
  logic [XLEN-1:0] shifted;

  assign size    = funct3[1:0];
  assign sext    = ~funct3[2];
  assign shifted = rdata >> {addr, 3'b000};

  assign wmask = byte_mask(size) << addr;
  assign wdata = store_data << {addr, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size)
      SZ_B:    load_data = {{(XLEN-8){shifted[7] & sext}}, shifted[7:0]};
      SZ_H:    load_data = {{(XLEN-16){shifted[15] & sext}}, shifted[15:0]};
      SZ_W:    load_data = {{(XLEN-32){shifted[31] & sext}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = addr[0];
      SZ_W:    misalign = |addr[1:0];
      SZ_D:    misalign = |addr;
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040127_lsu.sv
// Load/store unit: single-outstanding data-memory master that turns each execute
// result into exactly one writeback beat (memory op, fault or pass-through).
module ysyx_22040127_lsu
  import ysyx_22040127_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [XLEN-1:0]   req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [MASK_W-1:0] req_wmask,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_wen,
  output logic              wb_misalign
);

  logic [1:0]        state;
  logic [2:0]        lat_off;
  logic [2:0]        lat_funct3;
  logic              is_load;
  logic              is_store;
  logic [2:0]        align_off;
  logic [2:0]        align_funct3;
  logic [MASK_W-1:0] align_wmask;
  logic [XLEN-1:0]   align_wdata;
  logic [XLEN-1:0]   align_load;
  logic              align_misalign;

  assign in_ready  = (state == ST_IDLE);
  assign req_valid = (state == ST_REQ);
  assign wb_valid  = (state == ST_RESULT);

  // A set memread wins, so an instruction flagged as both is a load.
  assign is_load  = in_memread;
  assign is_store = in_memwrite & ~in_memread;

  // The aligner serves the incoming instruction in IDLE and the latched one later.
  assign align_off    = (state == ST_IDLE) ? in_alu_result[2:0] : lat_off;
  assign align_funct3 = (state == ST_IDLE) ? in_funct3 : lat_funct3;

  ysyx_22040127_lsu_align #(.XLEN(XLEN)) u_align (
    .addr       (align_off),
    .funct3     (align_funct3),
    .store_data (in_store_data),
    .rdata      (resp_rdata),
    .wmask      (align_wmask),
    .wdata      (align_wdata),
    .load_data  (align_load),
    .misalign   (align_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lat_off     <= '0;
      lat_funct3  <= '0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wmask   <= '0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_wen      <= 1'b0;
      wb_misalign <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            wb_rd       <= in_rd;
            wb_misalign <= 1'b0;
            lat_off     <= in_alu_result[2:0];
            lat_funct3  <= in_funct3;
            if (!is_load && !is_store) begin
              wb_data <= in_alu_result;
              wb_wen  <= (in_rd != '0);
              state   <= ST_RESULT;
            end else if (align_misalign) begin
              wb_data     <= in_alu_result;
              wb_wen      <= 1'b0;
              wb_misalign <= 1'b1;
              state       <= ST_RESULT;
            end else begin
              req_we    <= is_store;
              req_addr  <= {in_alu_result[XLEN-1:3], 3'b000};
              req_wmask <= is_store ? align_wmask : '0;
              req_wdata <= is_store ? align_wdata : '0;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (resp_valid) begin
            if (!req_we) begin
              wb_data <= align_load;
              wb_wen  <= (wb_rd != '0);
            end else begin
              wb_data <= '0;
              wb_wen  <= 1'b0;
            end
            state <= ST_RESULT;
          end
        end
        default: begin
          if (wb_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
